// File: rtl/countdown_timer.sv
// countdown_timer: loadable M:SS countdown timer with registered BCD digit outputs.
// A preset is loaded and then counted down to 0:00 in steps of `subtractor`
// seconds, once every TICK_DIV clock cycles.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN. When it is defined, the
// timer reloads the last preset on reaching zero instead of expiring.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] load_minutes0,
  input  logic [5:0] load_seconds1,
  input  logic [5:0] load_seconds0,
  input  logic       count,
  input  logic [5:0] subtractor,
  output logic [5:0] minutes0,
  output logic [5:0] seconds1,
  output logic [5:0] seconds0,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int unsigned TW = 10;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_EXP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          zero_hit;

  logic [5:0]    minutes0_d, seconds1_d, seconds0_d;
  logic          running_d, expired_d, done_d;
  logic [TW-1:0] rem_s;

  logic [5:0]    m0_cl, s1_cl, s0_cl;
  logic [TW-1:0] load_t;
  logic [TW-1:0] t_sub;
  logic          tick;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [TW-1:0] preset_q, preset_d;
`endif

  // Clamp preset digits and convert to total seconds.
  assign m0_cl  = (load_minutes0 > 6'd9) ? 6'd9 : load_minutes0;
  assign s1_cl  = (load_seconds1 > 6'd5) ? 6'd5 : load_seconds1;
  assign s0_cl  = (load_seconds0 > 6'd9) ? 6'd9 : load_seconds0;
  assign load_t = TW'(m0_cl) * TW'(60) + TW'(s1_cl) * TW'(10) + TW'(s0_cl);

  // Saturating subtraction: never wraps below zero.
  assign t_sub = (TW'(subtractor) >= t_q) ? '0 : (t_q - TW'(subtractor));
  assign tick  = (state_q == S_RUN) && (presc_q == PRESC_LAST);

  // State, value, prescaler and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      presc_q  <= '0;
      minutes0 <= '0;
      seconds1 <= '0;
      seconds0 <= '0;
      running  <= 1'b0;
      expired  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      presc_q  <= presc_d;
      minutes0 <= minutes0_d;
      seconds1 <= seconds1_d;
      seconds0 <= seconds0_d;
      running  <= running_d;
      expired  <= expired_d;
      done     <= done_d;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Last clamped preset, used for reload on reaching zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      preset_q <= '0;
    end else begin
      preset_q <= preset_d;
    end
  end
`endif

  // Next-state logic: load has priority, then per-state behaviour.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    presc_d  = presc_q;
    zero_hit = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    preset_d = preset_q;
`endif
    if (load) begin
      t_d     = load_t;
      presc_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      preset_d = load_t;
`endif
      if (load_t == '0) begin
        state_d = S_EXP;
      end else if (count) begin
        state_d = S_RUN;
      end else begin
        state_d = S_HOLD;
      end
    end else begin
      unique case (state_q)
        S_RUN: begin
          state_d = count ? S_RUN : S_HOLD;
          if (tick) begin
            presc_d = '0;
            if (t_sub == '0) begin
              zero_hit = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              t_d = preset_q;
`else
              t_d     = '0;
              state_d = S_EXP;
`endif
            end else begin
              t_d = t_sub;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_HOLD: begin
          if (count) begin
            state_d = S_RUN;
          end
        end
        S_IDLE, S_EXP: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output logic: BCD split of the next value and state flags.
  always_comb begin
    rem_s      = t_d % TW'(60);
    minutes0_d = 6'(t_d / TW'(60));
    seconds1_d = 6'(rem_s / TW'(10));
    seconds0_d = 6'(rem_s % TW'(10));
    running_d  = (state_d == S_RUN);
    expired_d  = (state_d == S_EXP);
    done_d     = zero_hit;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer (TICK_DIV=1 main instance, TICK_DIV=3 prescaler instance).
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [5:0] load_minutes0, load_seconds1, load_seconds0;
  logic       count;
  logic [5:0] subtractor;

  logic [5:0] m0_a, s1_a, s0_a;
  logic       run_a, exp_a, done_a;
  logic [5:0] m0_b, s1_b, s0_b;
  logic       run_b, exp_b, done_b;

  int checks;
  int failures;

  countdown_timer #(.TICK_DIV(1)) u_dut (
    .clk(clk), .reset(reset), .load(load),
    .load_minutes0(load_minutes0), .load_seconds1(load_seconds1), .load_seconds0(load_seconds0),
    .count(count), .subtractor(subtractor),
    .minutes0(m0_a), .seconds1(s1_a), .seconds0(s0_a),
    .running(run_a), .expired(exp_a), .done(done_a)
  );

  countdown_timer #(.TICK_DIV(3)) u_dut3 (
    .clk(clk), .reset(reset), .load(load),
    .load_minutes0(load_minutes0), .load_seconds1(load_seconds1), .load_seconds0(load_seconds0),
    .count(count), .subtractor(subtractor),
    .minutes0(m0_b), .seconds1(s1_b), .seconds0(s0_b),
    .running(run_b), .expired(exp_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Digits packed as M*100 + S1*10 + S0 for readable comparisons.
  function automatic int disp(input logic [5:0] m, input logic [5:0] a, input logic [5:0] b);
    return int'(m) * 100 + int'(a) * 10 + int'(b);
  endfunction

  // Expected display value for a total-seconds count.
  function automatic int tdisp(input int t);
    return (t / 60) * 100 + ((t % 60) / 10) * 10 + (t % 10);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [5:0] m, input logic [5:0] a, input logic [5:0] b,
                         input logic cnt, input logic [5:0] sub);
    load          = 1'b1;
    load_minutes0 = m;
    load_seconds1 = a;
    load_seconds0 = b;
    count         = cnt;
    subtractor    = sub;
    step(1);
    load          = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1; load = 1'b0; count = 1'b0; subtractor = 6'd0;
    load_minutes0 = 6'd0; load_seconds1 = 6'd0; load_seconds0 = 6'd0;

    // Reset state
    step(2);
    chk("rst_time", disp(m0_a, s1_a, s0_a), 0);
    chk("rst_running", int'(run_a), 0);
    chk("rst_expired", int'(exp_a), 0);
    chk("rst_done", int'(done_a), 0);
    reset = 1'b0;
    step(1);
    chk("idle_time", disp(m0_a, s1_a, s0_a), 0);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // Full countdown from 1:05
    do_load(6'd1, 6'd0, 6'd5, 1'b1, 6'd1);
    chk("t1_load_time", disp(m0_a, s1_a, s0_a), 105);
    chk("t1_load_running", int'(run_a), 1);
    chk("t1_load_done", int'(done_a), 0);
    for (int i = 1; i <= 65; i++) begin
      step(1);
      chk("t1_time", disp(m0_a, s1_a, s0_a), tdisp(65 - i));
      chk("t1_done", int'(done_a), (i == 65) ? 1 : 0);
    end
    chk("t1_expired", int'(exp_a), 1);
    chk("t1_running", int'(run_a), 0);
    step(3);
    chk("t1_exp_hold", int'(exp_a), 1);
    chk("t1_done_low", int'(done_a), 0);
    chk("t1_time_zero", disp(m0_a, s1_a, s0_a), 0);
`endif

    // Pause and resume from 0:30
    do_load(6'd0, 6'd3, 6'd0, 1'b1, 6'd1);
    chk("t2_load", disp(m0_a, s1_a, s0_a), 30);
    step(9);
    chk("t2_run9", disp(m0_a, s1_a, s0_a), 21);
    count = 1'b0;
    step(1);
    chk("t2_tick10", disp(m0_a, s1_a, s0_a), 20);
    chk("t2_hold_running", int'(run_a), 0);
    for (int i = 0; i < 19; i++) begin
      step(1);
      chk("t2_paused", disp(m0_a, s1_a, s0_a), 20);
    end
    count = 1'b1;
    step(1);
    chk("t2_resume_time", disp(m0_a, s1_a, s0_a), 20);
    chk("t2_resume_running", int'(run_a), 1);
    step(1);
    chk("t2_first_tick", disp(m0_a, s1_a, s0_a), 19);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // Saturating subtraction from 0:10 by 15
    do_load(6'd0, 6'd1, 6'd0, 1'b1, 6'd15);
    chk("t3_load", disp(m0_a, s1_a, s0_a), 10);
    step(1);
    chk("t3_sat_time", disp(m0_a, s1_a, s0_a), 0);
    chk("t3_done", int'(done_a), 1);
    chk("t3_expired", int'(exp_a), 1);
    step(1);
    chk("t3_done_once", int'(done_a), 0);
    chk("t3_exp_hold", int'(exp_a), 1);
`endif

    // Clamp 12,7,11 to 9:59, then load 0:00
    do_load(6'd12, 6'd7, 6'd11, 1'b0, 6'd1);
    chk("t4_clamp", disp(m0_a, s1_a, s0_a), 959);
    chk("t4_hold_running", int'(run_a), 0);
    chk("t4_hold_expired", int'(exp_a), 0);
    do_load(6'd0, 6'd0, 6'd0, 1'b1, 6'd1);
    chk("t4_zero_time", disp(m0_a, s1_a, s0_a), 0);
    chk("t4_zero_expired", int'(exp_a), 1);
    chk("t4_zero_done", int'(done_a), 0);
    step(1);
    chk("t4_zero_done2", int'(done_a), 0);

    // Load colliding with a tick, then reset mid-count
    do_load(6'd2, 6'd0, 6'd5, 1'b1, 6'd1);
    chk("t5_pre", disp(m0_a, s1_a, s0_a), 205);
    do_load(6'd2, 6'd0, 6'd0, 1'b1, 6'd1);
    chk("t5_load_wins", disp(m0_a, s1_a, s0_a), 200);
    step(1);
    chk("t5_next_tick", disp(m0_a, s1_a, s0_a), 159);
    step(29);
    chk("t5_at_130", disp(m0_a, s1_a, s0_a), 130);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t5_rst_time", disp(m0_a, s1_a, s0_a), 0);
    chk("t5_rst_running", int'(run_a), 0);
    chk("t5_rst_expired", int'(exp_a), 0);
    step(3);
    chk("t5_idle_time", disp(m0_a, s1_a, s0_a), 0);
    chk("t5_idle_running", int'(run_a), 0);

    // subtractor=0 never expires
    do_load(6'd0, 6'd0, 6'd2, 1'b1, 6'd0);
    step(5);
    chk("t7_sub0_time", disp(m0_a, s1_a, s0_a), 2);
    chk("t7_sub0_running", int'(run_a), 1);
    chk("t7_sub0_expired", int'(exp_a), 0);

    // Prescaler with TICK_DIV=3, holding its count across a pause
    do_load(6'd0, 6'd0, 6'd5, 1'b1, 6'd1);
    chk("t6_load", disp(m0_b, s1_b, s0_b), 5);
    step(2);
    chk("t6_no_tick_yet", disp(m0_b, s1_b, s0_b), 5);
    step(1);
    chk("t6_first_tick", disp(m0_b, s1_b, s0_b), 4);
    count = 1'b0;
    step(1);
    chk("t6_pause_running", int'(run_b), 0);
    step(5);
    chk("t6_paused", disp(m0_b, s1_b, s0_b), 4);
    count = 1'b1;
    step(2);
    chk("t6_resume_wait", disp(m0_b, s1_b, s0_b), 4);
    step(1);
    chk("t6_resume_tick", disp(m0_b, s1_b, s0_b), 3);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Auto reload from 0:03
    do_load(6'd0, 6'd0, 6'd3, 1'b1, 6'd1);
    chk("ar_load", disp(m0_a, s1_a, s0_a), 3);
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk("ar_time", disp(m0_a, s1_a, s0_a), (i % 3 == 0) ? 3 : (3 - (i % 3)));
      chk("ar_done", int'(done_a), (i % 3 == 0) ? 1 : 0);
      chk("ar_expired", int'(exp_a), 0);
      chk("ar_running", int'(run_a), 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable M:SS countdown timer for the music player: counts a preset playback time (for example, remaining track time or a sleep timer) down to 0:00 and flags expiry. It is the down-counting counterpart of the playback `Timer`. It presents the same three 6-bit digit outputs, so the existing `driver7seg` instances can display it unchanged.

## Interface
- `TICK_DIV`, default 1: clock cycles per decrement tick (≥1).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `load` in 1: load preset digits (single-cycle strobe, level also accepted).
- `load_minutes0` in 6: preset minutes digit.
- `load_seconds1` in 6: preset tens-of-seconds digit.
- `load_seconds0` in 6: preset units-of-seconds digit.
- `count` in 1: run enable; 0 pauses without losing value.
- `subtractor` in 6: seconds removed per tick (0–63).
- `minutes0` out 6: current minutes digit (0–9).
- `seconds1` out 6: current tens-of-seconds digit (0–5).
- `seconds0` out 6: current units-of-seconds digit (0–9).
- `running` out 1: high in RUN state.
- `expired` out 1: level, high in EXPIRED state.
- `done` out 1: one-cycle pulse on the RUN→EXPIRED transition.

## Operation
- Internal value: 10-bit total seconds `t` (0–599). Digit outputs are a registered BCD split of `t`.
- Load clamps each preset digit: `s0` >9→9, `s1` >5→5, `m0` >9→9. It then sets `t = m0*60 + s1*10 + s0`.
- States: IDLE, RUN, HOLD, EXPIRED. Reset enters IDLE with `t`=0.
- `load` takes priority from any state:
  - `t` = 0 → EXPIRED, no `done` pulse.
  - else `count`=1 → RUN.
  - else → HOLD.
- RUN:
  - `count`=0 → HOLD.
  - On a tick, `t ← max(t − subtractor, 0)`.
  - If the result is 0 → EXPIRED and `done`=1 for that cycle.
- HOLD: `count`=1 → RUN. `t` is frozen.
- IDLE and EXPIRED: ignore `count` and `subtractor`. They leave only on `load` or reset.
- `subtractor`=0 in RUN: ticks occur but `t` is unchanged, and the block never expires.
- Saturation: `subtractor` greater than `t` yields exactly 0:00, never a wrap to 9:59.

## Timing
- Reset values:
  - `minutes0`/`seconds1`/`seconds0`=0.
  - `running`=0, `expired`=0, `done`=0.
  - Prescaler=0, state IDLE.
- Prescaler:
  - Counts 0..TICK_DIV−1 only in RUN. A tick fires on the cycle it equals TICK_DIV−1, then it wraps to 0.
  - It holds its count in HOLD.
  - It clears on `load`, on entering EXPIRED, and on reset.
- Latency:
  - Load: digits and state update on the edge where `load`=1 is sampled, visible the next cycle.
  - Tick: the decremented digits are visible 1 cycle after the tick edge.
  - `done` and `expired` rise together with digits reading 0:00.
- Simultaneous events:
  - `load` + tick in the same cycle: load wins and the tick is discarded.
  - `reset` + anything: reset wins.
  - `count` falling on a tick cycle: the tick is still applied, then the state moves to HOLD.
- Reset mid-count: the value is lost and outputs return to 0:00 in IDLE on the next cycle.
- First tick after a load into RUN occurs TICK_DIV cycles after the load edge.

## Configuration
- `COUNTDOWN_AUTO_RELOAD_EN` defined:
  - The block keeps the last clamped preset.
  - On RUN reaching 0, it pulses `done` for one cycle but reloads the preset and stays in RUN. EXPIRED is reached only when the preset is 0.
  - `expired` is then high only in that case.
- Macro undefined: behaviour is exactly as described in Operation, and no preset register is synthesized.

## Test plan
- Reset, then load 1:05, `count`=1, `subtractor`=1, TICK_DIV=1 → digits 1:05, 1:04 … 0:01, 0:00. `done` is a one-cycle pulse exactly 65 cycles after the load edge, and `expired` stays high afterwards.
- Load 0:30, run 10 ticks, `count`=0 for 20 cycles, then `count`=1 → digits hold at 0:20 during the pause and resume to 0:19 on the first tick.
- Load 0:10, `subtractor`=15 → after the first tick digits read 0:00 (no wrap), and `done` pulses once.
- Load digits 12, 7, 11 (m0, s1, s0) → clamped to 9:59 (`t`=599). A load of 0:00 → `expired`=1 with `done` never asserted.
- `load` of 2:00 in the same cycle as a tick, and a `reset` asserted mid-count at 1:30 → the load shows 2:00 with no decrement applied. After the reset, outputs read 0:00 with `running`=0, `expired`=0, and the block stays in IDLE despite `count`=1.
- With `COUNTDOWN_AUTO_RELOAD_EN` defined: load 0:03, `subtractor`=1 → sequence 0:03, 0:02, 0:01, 0:03 … with a `done` pulse at each wrap and `expired` staying 0.
